// File: rtl/mask_matcher16.sv
`default_nettype none
// ============================================================================
// Module   : mask_matcher16
// Brief    : Aligns sparse W/A operand streams via a mutual nonzero mask and
//            emits packed per-stream consume masks plus operand counts,
//            behind one valid/ready output register.
// Revision : 1.0
// ============================================================================
module mask_matcher16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        ivalid,
    output logic        iready,
    output logic        ovalid,
    input  logic        oready,
    input  logic [15:0] bitmaskW,
    input  logic [15:0] bitmaskA,
    output logic [63:0] result
);

    logic [15:0] w_mutual;
    logic [15:0] w_packedW;
    logic [15:0] w_packedA;
    logic [4:0]  w_numW;
    logic [4:0]  w_numA;
    logic [63:0] w_result;

    logic [63:0] r_result;
    logic        r_ovalid;

    assign w_mutual = bitmaskW & bitmaskA;

    // Running prefix counts: before lane i each is at most i (< 16), so the
    // low four bits index the packed mask directly.
    always_comb begin
        logic [4:0] cntW;
        logic [4:0] cntA;
        w_packedW = '0;
        w_packedA = '0;
        cntW      = '0;
        cntA      = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_mutual[i]) begin
                w_packedW[cntW[3:0]] = 1'b1;
                w_packedA[cntA[3:0]] = 1'b1;
            end
            cntW = cntW + {4'b0000, bitmaskW[i]};
            cntA = cntA + {4'b0000, bitmaskA[i]};
        end
        w_numW = cntW;
        w_numA = cntA;
    end

    assign w_result = {19'b0, w_numA, 3'b000, w_numW, w_packedA, w_packedW};

    assign iready = oready | ~r_ovalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovalid <= 1'b0;
            r_result <= '0;
        end else if (ivalid && iready) begin
            r_ovalid <= 1'b1;
            r_result <= w_result;
        end else if (oready) begin
            r_ovalid <= 1'b0;
        end
    end

    assign ovalid = r_ovalid;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mask_matcher16.sv
`default_nettype none
// ============================================================================
// Module   : tb_mask_matcher16
// Brief    : Directed self-checking bench for mask_matcher16.
// Revision : 1.0
// ============================================================================
module tb_mask_matcher16;

    logic        clock = 1'b0;
    logic        reset;
    logic        ivalid;
    logic        iready;
    logic        ovalid;
    logic        oready;
    logic [15:0] bitmaskW;
    logic [15:0] bitmaskA;
    logic [63:0] result;

    int testsRun    = 0;
    int testsFailed = 0;

    mask_matcher16 dut (
        .clock    (clock),
        .reset    (reset),
        .ivalid   (ivalid),
        .iready   (iready),
        .ovalid   (ovalid),
        .oready   (oready),
        .bitmaskW (bitmaskW),
        .bitmaskA (bitmaskA),
        .result   (result)
    );

    always #5 clock = ~clock;

    // Hand-computed packed results: {19'b0, numA, 3'b0, numW, packedA, packedW}
    localparam logic [63:0] C_EXP_FFFF_0000 = 64'h0000_0010_0000_0000;
    localparam logic [63:0] C_EXP_FFFF_FFFF = 64'h0000_1010_FFFF_FFFF;
    localparam logic [63:0] C_EXP_F00F_FFFF = 64'h0000_1008_F00F_00FF;
    localparam logic [63:0] C_EXP_00AA_00F0 = 64'h0000_0404_000A_000C;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        ivalid   = 1'b0;
        oready   = 1'b1;
        bitmaskW = 16'h0000;
        bitmaskA = 16'h0000;
        tick();
        tick();
        check("reset_ovalid", {63'b0, ovalid}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_iready", {63'b0, iready}, 64'd1);

        // Back-to-back transfers with oready held high
        reset    = 1'b0;
        ivalid   = 1'b1;
        bitmaskW = 16'hFFFF;
        bitmaskA = 16'h0000;
        tick();
        check("w_all_ovalid", {63'b0, ovalid}, 64'd1);
        check("w_all_result", result, C_EXP_FFFF_0000);

        bitmaskW = 16'hFFFF;
        bitmaskA = 16'hFFFF;
        tick();
        check("both_all_ovalid", {63'b0, ovalid}, 64'd1);
        check("both_all_result", result, C_EXP_FFFF_FFFF);

        bitmaskW = 16'hF00F;
        bitmaskA = 16'hFFFF;
        tick();
        check("f00f_result", result, C_EXP_F00F_FFFF);

        bitmaskW = 16'h0000;
        bitmaskA = 16'h0000;
        tick();
        check("zero_ovalid", {63'b0, ovalid}, 64'd1);
        check("zero_result", result, 64'd0);

        bitmaskW = 16'h00AA;
        bitmaskA = 16'h00F0;
        tick();
        check("aa_f0_result", result, C_EXP_00AA_00F0);

        // Drain: ovalid clears, result holds
        ivalid = 1'b0;
        tick();
        check("drain_ovalid", {63'b0, ovalid}, 64'd0);
        check("drain_result_hold", result, C_EXP_00AA_00F0);

        // Stall: accept one, then hold oready low for three cycles
        oready   = 1'b0;
        ivalid   = 1'b1;
        bitmaskW = 16'hF00F;
        bitmaskA = 16'hFFFF;
        tick();
        check("stall_load_result", result, C_EXP_F00F_FFFF);
        bitmaskW = 16'hFFFF;
        bitmaskA = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            check("stall_iready", {63'b0, iready}, 64'd0);
            tick();
            check("stall_ovalid", {63'b0, ovalid}, 64'd1);
            check("stall_result", result, C_EXP_F00F_FFFF);
        end

        // Release: pending input and a follow-up emerge on consecutive cycles
        oready = 1'b1;
        #1;
        check("release_iready", {63'b0, iready}, 64'd1);
        tick();
        check("release_result0", result, C_EXP_FFFF_FFFF);
        bitmaskW = 16'h00AA;
        bitmaskA = 16'h00F0;
        tick();
        check("release_result1", result, C_EXP_00AA_00F0);
        check("release_ovalid1", {63'b0, ovalid}, 64'd1);

        // Reset mid-stream overrides a simultaneous transfer
        bitmaskW = 16'hFFFF;
        bitmaskA = 16'h0000;
        reset    = 1'b1;
        tick();
        check("midreset_ovalid", {63'b0, ovalid}, 64'd0);
        check("midreset_result", result, 64'd0);
        check("midreset_iready", {63'b0, iready}, 64'd1);

        reset  = 1'b0;
        ivalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
`default_nettype wire
